// File: rtl/marian_multi_inval_filter.sv
// Multi-hart L1 invalidation filter for the Ara AXI write path.
// Every accepted AW becomes one FIFO entry holding its first line and line count.
// An engine walks the entries and broadcasts one invalidation per line to all harts.
// A write's B response is released only after all of its lines have been acknowledged.
module marian_multi_inval_filter #(
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned NrHarts   = 1,
    parameter int unsigned MaxTxns   = 4,
    parameter int unsigned LineBytes = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 slv_aw_valid_i,
    output logic                 slv_aw_ready_o,
    input  logic [AddrWidth-1:0] slv_aw_addr_i,
    input  logic [7:0]           slv_aw_len_i,
    input  logic [2:0]           slv_aw_size_i,
    output logic                 mst_aw_valid_o,
    input  logic                 mst_aw_ready_i,
    input  logic                 mst_b_valid_i,
    output logic                 mst_b_ready_o,
    output logic                 slv_b_valid_o,
    input  logic                 slv_b_ready_i,
    output logic [AddrWidth-1:0] inval_addr_o,
    output logic [NrHarts-1:0]   inval_valid_o,
    input  logic [NrHarts-1:0]   inval_ready_i,
    output logic                 busy_o
);

    localparam int unsigned LineOffBits = $clog2(LineBytes);
    localparam int unsigned IdxW        = $clog2(MaxTxns);
    localparam int unsigned PtrW        = IdxW + 1;
    localparam int unsigned LineW       = AddrWidth - LineOffBits;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ISSUE
    } state_e;

    // Outstanding-write FIFO storage
    logic [LineW-1:0] fifo_first  [MaxTxns];
    logic [12:0]      fifo_nlines [MaxTxns];

    // wr: next free slot, iv: entry being invalidated, bp: entry awaiting B
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] iv_ptr;
    logic [PtrW-1:0] bp_ptr;

    logic full;
    logic aw_hs;
    logic b_ok;
    logic b_hs;

    logic [AddrWidth-1:0] aw_bytes;
    logic [AddrWidth-1:0] aw_last_addr;
    logic [LineW-1:0]     aw_first;
    logic [LineW-1:0]     aw_last;
    logic [12:0]          aw_nlines;

    state_e             state;
    logic [LineW-1:0]   cur_line;
    logic [12:0]        remaining;
    logic [NrHarts-1:0] ack_mask;
    logic [NrHarts-1:0] inval_hs;
    logic [NrHarts-1:0] ack_next;

    // Burst footprint in cache lines; address wrap is modulo 2^AddrWidth
    always_comb begin
        aw_bytes     = (AddrWidth'(slv_aw_len_i) + AddrWidth'(1)) << slv_aw_size_i;
        aw_last_addr = slv_aw_addr_i + aw_bytes - AddrWidth'(1);
        aw_first     = LineW'(slv_aw_addr_i >> LineOffBits);
        aw_last      = LineW'(aw_last_addr >> LineOffBits);
        aw_nlines    = en_i ? 13'(aw_last - aw_first + LineW'(1)) : '0;
    end

    // AW/B gating; fullness uses the pre-retire count so a retire never bypasses into AW ready
    always_comb begin
        full           = (wr_ptr - bp_ptr) == PtrW'(MaxTxns);
        aw_hs          = slv_aw_valid_i & mst_aw_ready_i & ~full;
        mst_aw_valid_o = slv_aw_valid_i & ~full;
        slv_aw_ready_o = mst_aw_ready_i & ~full;
        b_ok           = bp_ptr != iv_ptr;
        b_hs           = mst_b_valid_i & slv_b_ready_i & b_ok;
        slv_b_valid_o  = mst_b_valid_i & b_ok;
        mst_b_ready_o  = slv_b_ready_i & b_ok;
        busy_o         = (wr_ptr != bp_ptr) | (state != IDLE);
    end

    // Per-hart acknowledge accumulation for the line currently on the bus
    always_comb begin
        inval_hs = inval_valid_o & inval_ready_i;
        ack_next = ack_mask | inval_hs;
    end

    // FIFO write side: one entry per accepted AW
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            for (int unsigned i = 0; i < MaxTxns; i++) begin
                fifo_first[i]  <= '0;
                fifo_nlines[i] <= '0;
            end
        end else if (aw_hs) begin
            fifo_first[wr_ptr[IdxW-1:0]]  <= aw_first;
            fifo_nlines[wr_ptr[IdxW-1:0]] <= aw_nlines;
            wr_ptr                        <= wr_ptr + PtrW'(1);
        end
    end

    // FIFO retire side: B handshake frees the head entry
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bp_ptr <= '0;
        end else if (b_hs) begin
            bp_ptr <= bp_ptr + PtrW'(1);
        end
    end

    // Invalidation engine; inval_valid_o is kept equal to ~ack_mask while issuing
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= IDLE;
            iv_ptr        <= '0;
            cur_line      <= '0;
            remaining     <= '0;
            ack_mask      <= '0;
            inval_valid_o <= '0;
            inval_addr_o  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (iv_ptr != wr_ptr) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    cur_line  <= fifo_first[iv_ptr[IdxW-1:0]];
                    remaining <= fifo_nlines[iv_ptr[IdxW-1:0]];
                    ack_mask  <= '0;
                    if (fifo_nlines[iv_ptr[IdxW-1:0]] == '0) begin
                        iv_ptr <= iv_ptr + PtrW'(1);
                        state  <= IDLE;
                    end else begin
                        inval_valid_o <= '1;
                        inval_addr_o  <= {fifo_first[iv_ptr[IdxW-1:0]], {LineOffBits{1'b0}}};
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (&ack_next) begin
                        ack_mask <= '0;
                        if (remaining == 13'd1) begin
                            remaining     <= '0;
                            inval_valid_o <= '0;
                            iv_ptr        <= iv_ptr + PtrW'(1);
                            state         <= IDLE;
                        end else begin
                            remaining     <= remaining - 13'd1;
                            cur_line      <= cur_line + LineW'(1);
                            inval_valid_o <= '1;
                            inval_addr_o  <= {cur_line + LineW'(1), {LineOffBits{1'b0}}};
                        end
                    end else begin
                        ack_mask      <= ack_next;
                        inval_valid_o <= ~ack_next;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // A B response with nothing outstanding means the downstream fabric misbehaved
    assert property (@(posedge clk_i) disable iff (rst_i) mst_b_valid_i |-> (wr_ptr != bp_ptr));

endmodule

// File: doc/marian_multi_inval_filter.md
Name: marian_multi_inval_filter

Overview:
- Snoops the wide accelerator (Ara) AXI write path and keeps the scalar cores' L1 data caches coherent with vector stores.
- Successor of the single-hart invalidation filter. It broadcasts to NrHarts cores, splits each write burst into per-line invalidations, and tracks up to MaxTxns outstanding writes.
- Holds each write's B response until every hart has acknowledged every line that write touches.
- Sits between the Ara master port and the system AXI mux. It only gates AW and B valid/ready; payloads are routed outside the block.

Parameters:
- AddrWidth, 64, AXI address width.
- NrHarts, 1, number of cores receiving invalidations (1..8).
- MaxTxns, 4, outstanding-write FIFO depth (power of 2, at least 2).
- LineBytes, 16, L1 D-cache line size in bytes (power of 2). LineOffBits = log2(LineBytes).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- en_i  in  1  coherence enable (acc_cons_en), sampled at AW handshake.
- slv_aw_valid_i  in  1  AW valid from Ara.
- slv_aw_ready_o  out  1  AW ready to Ara.
- slv_aw_addr_i  in  AddrWidth  AW address.
- slv_aw_len_i  in  8  AW burst length minus 1.
- slv_aw_size_i  in  3  AW beat size, log2 bytes.
- mst_aw_valid_o  out  1  AW valid to mux.
- mst_aw_ready_i  in  1  AW ready from mux.
- mst_b_valid_i  in  1  B valid from mux.
- mst_b_ready_o  out  1  B ready to mux.
- slv_b_valid_o  out  1  B valid to Ara.
- slv_b_ready_i  in  1  B ready from Ara.
- inval_addr_o  out  AddrWidth  line-aligned invalidation address (common to all harts).
- inval_valid_o  out  NrHarts  per-hart invalidation valid.
- inval_ready_i  in  NrHarts  per-hart invalidation ready.
- busy_o  out  1  FIFO non-empty or engine active.

Behaviour:

Reset:
- rst_i asserted, including mid-operation: FIFO, pointers, counters, ack mask and FSM cleared immediately.
- All outputs 0 (inval_addr_o 0, busy_o 0). Partially issued invalidations and held B responses are dropped.

AW path (combinational, no added latency):
- mst_aw_valid_o = slv_aw_valid_i & !full.
- slv_aw_ready_o = mst_aw_ready_i & !full.
- Handshake = slv_aw_valid_i & mst_aw_ready_i & !full. Each handshake pushes one entry {first_line, nlines}.

Line arithmetic:
- bytes = (len+1) << size.
- first = addr >> LineOffBits.
- last = (addr + bytes - 1) >> LineOffBits, computed in AddrWidth bits. 4 KiB crossing is illegal AXI; wrap at the top of the address space is truncated modulo 2^AddrWidth.
- nlines = last - first + 1, held in 13 bits.
- en_i = 0 at handshake: nlines = 0.

FIFO:
- Three pointers, each log2(MaxTxns)+1 bits: wr, iv (invalidation head), bp (B head).
- full = (wr - bp) == MaxTxns.
- Push and B retire in the same cycle are allowed when full: the retire frees a slot, but ready is computed from the pre-retire count (no bypass).

Invalidation FSM, entry at iv when iv != wr:
- IDLE -> LOAD when an entry is pending.
- LOAD (1 cycle): line = first, remaining = nlines, ack_mask = 0. If remaining == 0: iv++ and go to IDLE.
- ISSUE:
  - inval_addr_o = line << LineOffBits.
  - inval_valid_o[h] = !ack_mask[h].
  - ack_mask[h] sets when inval_valid_o[h] & inval_ready_i[h].
  - When all bits of (ack_mask | handshakes this cycle) are 1: clear ack_mask, line++, remaining--.
  - If remaining hits 0: iv++ and go to IDLE; else stay in ISSUE.
  - A line with all harts ready takes 1 cycle.
- Harts acknowledge independently. A hart that already acked sees valid low until the next line.
- inval_valid_o is low in IDLE/LOAD; inval_addr_o holds its last value.
- First inval_valid_o rises 2 cycles after the AW handshake.

B path:
- b_ok = (bp != iv), i.e. the head write's invalidations are complete.
- slv_b_valid_o = mst_b_valid_i & b_ok.
- mst_b_ready_o = slv_b_ready_i & b_ok.
- Handshake retires the entry (bp++). B order equals AW order (single Ara ID).
- A B arriving before its invalidations finish is stalled, not dropped.
- A B arriving with the FIFO empty is stalled (protocol error, assertion).

Other:
- en_i changing while entries are queued does not affect them.
- busy_o = (wr != bp) | (state != IDLE).

Test Plan:
1. Reset release, NrHarts=2, en_i=1. AW addr 0x8000_0008, len 3, size 3 (32 B) -> inval_addr_o 0x8000_0000 then 0x8000_0010 then 0x8000_0020, each with inval_valid_o=2'b11. B from the mux is held (slv_b_valid_o=0) until the third line is acked by both harts.
2. Same AW with hart1 ready delayed 3 cycles -> inval_valid_o goes 11 -> 10 (hart0 acked) and holds 10 until hart1 acks. The line advances only then; hart0 is not re-requested.
3. en_i=0, AW addr 0x100, len 7, size 4 -> no inval_valid_o. B passes 2 cycles after the AW handshake (LOAD, then b_ok).
4. MaxTxns=4: 5 back-to-back AWs with mst_aw_ready_i=1 and slv_b_ready_i=0 -> slv_aw_ready_o=0 on the 5th. It rises in the cycle after the first B retires. B responses come out in AW order.
5. Assert rst_i mid-ISSUE with 2 entries queued -> all outputs 0 asynchronously, busy_o=0. The next AW after release restarts from an empty FIFO.
6. Single-byte AW at 0x1F (len 0, size 0), LineBytes 16 -> exactly one invalidation at 0x10. AW len 255, size 4 at 0x0 -> 256 invalidations, 0x0 through 0xFF0.
